// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmitter and receiver.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_BIT_CYCLES = 16;
endpackage

// File: rtl/tx_if_if.sv
// Byte handshake bundle between a byte source (master) and the transmitter (slave).
interface tx_if_if;
  logic [7:0] din;
  logic       tx_vld;
  logic       tx_rdy;

  modport master (output din, output tx_vld, input tx_rdy);
  modport slave  (input din, input tx_vld, output tx_rdy);
endinterface

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO with sync active-high reset and full/empty flags.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push_ok, w_pop_ok;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop_ok)  r_rp <= r_rp + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/tx_if.sv
// UART transmitter: 8N1 frames, BIT_CYCLES clocks per bit.
// Define TX_FIFO_EN to buffer FIFO_DEPTH bytes and send frames back-to-back.
module tx_if
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       txd,
  output logic       tx_busy
);
  localparam int            CW   = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  uart_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_byte;
  logic          r_txd;

  logic       w_bit_end, w_slot, w_accept, w_load, w_nempty;
  logic [7:0] w_load_byte;

  assign w_bit_end = (r_cnt == LAST);
  // A new frame may begin from IDLE or right at the end of a stop bit.
  assign w_slot    = (r_state == IDLE) || (r_state == STOP && w_bit_end);
  assign w_accept  = tx_vld && tx_rdy;

`ifdef TX_FIFO_EN
  logic       w_full, w_empty, w_push, w_pop;
  logic [7:0] w_head;

  assign tx_rdy      = !w_full && !rst;
  assign w_pop       = w_slot && !w_empty;
  // Bypass the FIFO when it is empty and the shifter can start right now.
  assign w_push      = w_accept && !(w_slot && w_empty);
  assign w_load      = w_slot && (!w_empty || w_accept);
  assign w_load_byte = w_empty ? din : w_head;
  assign w_nempty    = !w_empty;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (din),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
`else
  logic w_unused_depth;

  assign tx_rdy         = (r_state == IDLE) && !rst;
  assign w_load         = w_accept;
  assign w_load_byte    = din;
  assign w_nempty       = 1'b0;
  assign w_unused_depth = (FIFO_DEPTH > 0);
`endif

  assign txd     = r_txd;
  assign tx_busy = (r_state != IDLE) || w_nempty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_load) begin
            r_state <= START;
            r_byte  <= w_load_byte;
            r_txd   <= 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= DATA;
            r_txd   <= r_byte[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
              r_txd   <= 1'b1;
            end else begin
              r_idx  <= r_idx + 1'b1;
              r_txd  <= r_byte[1];
              r_byte <= {1'b0, r_byte[7:1]};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_load) begin
              r_state <= START;
              r_byte  <= w_load_byte;
              r_txd   <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
